// File: rtl/instr_loader.sv
// Instruction loader: debounced push-button capture of IN_W-bit chunks, assembled
// LSB-first into an INSTR_W-bit word and handed to the fetch stage via valid/ready.
module instr_loader #(
  parameter  int IN_W            = 8,
  parameter  int INSTR_W         = 16,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int NCHUNK          = INSTR_W / IN_W,
  localparam int CW              = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    din,
  input  logic               btn,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [CW-1:0]      chunk_idx,
  output logic               hold,
  output logic               overrun
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     btn_s;
  logic                     deb_level;
  logic [DW-1:0]            deb_cnt;
  logic                     press;
  logic [CW-1:0]            idx_d;
  logic [INSTR_W-1:0]       instr_d;
  logic                     overrun_d;

  // Metastability guard for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // The level only flips after btn_s has disagreed with it for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (btn_s == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_LAST) begin
      deb_level <= ~deb_level;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign press = btn_s & ~deb_level & (deb_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      chunk_idx <= '0;
      instr_out <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      chunk_idx <= idx_d;
      instr_out <= instr_d;
      overrun   <= overrun_d;
    end
  end

  // A press landing on the transfer edge starts the next instruction instead of being lost.
  always_comb begin
    state_d   = state_q;
    idx_d     = chunk_idx;
    instr_d   = instr_out;
    overrun_d = overrun;
    if (abort) begin
      state_d   = S_FILL;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (press) begin
            for (int i = 0; i < NCHUNK; i++) begin
              if (chunk_idx == CW'(i)) begin
                instr_d[i*IN_W +: IN_W] = din;
              end
            end
            if (chunk_idx == LAST_IDX) begin
              idx_d   = '0;
              state_d = S_HOLD;
            end else begin
              idx_d = chunk_idx + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            state_d = S_FILL;
            if (press) begin
              instr_d[IN_W-1:0] = din;
              if (NCHUNK == 1) begin
                state_d = S_HOLD;
              end else begin
                idx_d = CW'(1);
              end
            end
          end else if (press) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d = S_FILL;
        end
      endcase
    end
  end

  assign instr_valid = (state_q == S_HOLD);
  assign hold        = (state_q == S_HOLD);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a default 16-bit instance and a 24-bit instance
// share clock, reset, din and abort but have their own buttons and ready inputs.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        abort;
  logic        btn16;
  logic        btn24;
  logic        ready16;
  logic        ready24;
  logic [15:0] instr16;
  logic [23:0] instr24;
  logic        valid16;
  logic        valid24;
  logic [0:0]  idx16;
  logic [1:0]  idx24;
  logic        hold16;
  logic        hold24;
  logic        ovr16;
  logic        ovr24;

  int errors = 0;
  int checks = 0;

  instr_loader dut16 (
    .clk(clk), .rst_n(rst_n), .din(din), .btn(btn16), .abort(abort),
    .instr_out(instr16), .instr_valid(valid16), .instr_ready(ready16),
    .chunk_idx(idx16), .hold(hold16), .overrun(ovr16)
  );

  instr_loader #(.IN_W(8), .INSTR_W(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .din(din), .btn(btn24), .abort(abort),
    .instr_out(instr24), .instr_valid(valid24), .instr_ready(ready24),
    .chunk_idx(idx24), .hold(hold24), .overrun(ovr24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full press and release; six edges to capture, seven to settle the release.
  task automatic apply_stimulus(input bit sel24, input logic [7:0] data);
    din = data;
    if (sel24) btn24 = 1'b1; else btn16 = 1'b1;
    repeat (6) tick();
    btn16 = 1'b0;
    btn24 = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    rst_n = 1'b1; din = 8'h00; abort = 1'b0;
    btn16 = 1'b0; btn24 = 1'b0; ready16 = 1'b0; ready24 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_output("rst_instr", 32'(instr16), 32'h0);
    check_output("rst_valid", 32'(valid16), 32'h0);
    check_output("rst_idx", 32'(idx16), 32'h0);
    check_output("rst_hold", 32'(hold16), 32'h0);
    check_output("rst_ovr", 32'(ovr16), 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Two chunks, consumer always ready.
    din = 8'hA5; btn16 = 1'b1;
    repeat (5) tick();
    check_output("t1_no_early_capture", 32'(idx16), 32'h0);
    tick();
    check_output("t1_idx_after_c0", 32'(idx16), 32'h1);
    check_output("t1_instr_after_c0", 32'(instr16), 32'h00A5);
    btn16 = 1'b0;
    repeat (7) tick();
    check_output("t1_release_no_strobe", 32'(idx16), 32'h1);
    ready16 = 1'b1;
    din = 8'h3C; btn16 = 1'b1;
    repeat (6) tick();
    check_output("t1_valid", 32'(valid16), 32'h1);
    check_output("t1_hold", 32'(hold16), 32'h1);
    check_output("t1_instr", 32'(instr16), 32'h3CA5);
    check_output("t1_idx_wrap", 32'(idx16), 32'h0);
    tick();
    check_output("t1_valid_pulse", 32'(valid16), 32'h0);
    check_output("t1_hold_clear", 32'(hold16), 32'h0);
    btn16 = 1'b0;
    repeat (7) tick();
    ready16 = 1'b0;

    // Bouncing button never satisfies the debounce window.
    din = 8'h5A;
    btn16 = 1'b1; repeat (3) tick();
    btn16 = 1'b0; tick();
    btn16 = 1'b1; repeat (3) tick();
    btn16 = 1'b0; repeat (8) tick();
    check_output("t2_bounce_idx", 32'(idx16), 32'h0);
    check_output("t2_bounce_instr", 32'(instr16), 32'h3CA5);
    btn16 = 1'b1;
    repeat (5) tick();
    check_output("t2_clean_pre", 32'(idx16), 32'h0);
    tick();
    check_output("t2_clean_idx", 32'(idx16), 32'h1);
    check_output("t2_clean_instr", 32'(instr16), 32'h3C5A);
    btn16 = 1'b0;
    repeat (7) tick();

    // Backpressure and overrun.
    apply_stimulus(1'b0, 8'h3C);
    check_output("t3_valid", 32'(valid16), 32'h1);
    check_output("t3_instr", 32'(instr16), 32'h3C5A);
    check_output("t3_ovr_before", 32'(ovr16), 32'h0);
    apply_stimulus(1'b0, 8'hFF);
    check_output("t3_ovr_set", 32'(ovr16), 32'h1);
    check_output("t3_instr_frozen", 32'(instr16), 32'h3C5A);
    check_output("t3_valid_held", 32'(valid16), 32'h1);
    ready16 = 1'b1;
    tick();
    ready16 = 1'b0;
    check_output("t3_transfer", 32'(valid16), 32'h0);
    check_output("t3_ovr_sticky", 32'(ovr16), 32'h1);

    // Abort clears progress and overrun but not the data; an aborted strobe is dropped.
    apply_stimulus(1'b0, 8'h11);
    check_output("t4_idx_c0", 32'(idx16), 32'h1);
    check_output("t4_instr_c0", 32'(instr16), 32'h3C11);
    abort = 1'b1; tick(); abort = 1'b0;
    check_output("t4_abort_idx", 32'(idx16), 32'h0);
    check_output("t4_abort_ovr", 32'(ovr16), 32'h0);
    check_output("t4_abort_instr", 32'(instr16), 32'h3C11);
    din = 8'h99; btn16 = 1'b1;
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    btn16 = 1'b0;
    repeat (7) tick();
    check_output("t4_drop_idx", 32'(idx16), 32'h0);
    check_output("t4_drop_instr", 32'(instr16), 32'h3C11);
    apply_stimulus(1'b0, 8'h22);
    apply_stimulus(1'b0, 8'h33);
    check_output("t4_valid", 32'(valid16), 32'h1);
    check_output("t4_instr", 32'(instr16), 32'h3322);
    ready16 = 1'b1; tick(); ready16 = 1'b0;
    check_output("t4_transfer", 32'(valid16), 32'h0);

    // Three-chunk instance, then a press on the transfer edge.
    apply_stimulus(1'b1, 8'h01);
    check_output("t5_idx1", 32'(idx24), 32'h1);
    apply_stimulus(1'b1, 8'h02);
    check_output("t5_idx2", 32'(idx24), 32'h2);
    apply_stimulus(1'b1, 8'h03);
    check_output("t5_valid", 32'(valid24), 32'h1);
    check_output("t5_instr", 32'(instr24), 32'h030201);
    check_output("t5_idx_wrap", 32'(idx24), 32'h0);
    din = 8'hAA; btn24 = 1'b1;
    repeat (5) tick();
    ready24 = 1'b1;
    tick();
    ready24 = 1'b0;
    check_output("t5_coinc_valid", 32'(valid24), 32'h0);
    check_output("t5_coinc_idx", 32'(idx24), 32'h1);
    check_output("t5_coinc_ovr", 32'(ovr24), 32'h0);
    check_output("t5_coinc_instr", 32'(instr24), 32'h0302AA);
    btn24 = 1'b0;
    repeat (7) tick();

    // Asynchronous reset mid-fill and mid-debounce.
    apply_stimulus(1'b0, 8'h44);
    check_output("t6_pre_idx", 32'(idx16), 32'h1);
    din = 8'h55; btn16 = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("t6_rst_idx", 32'(idx16), 32'h0);
    check_output("t6_rst_instr", 32'(instr16), 32'h0);
    check_output("t6_rst_valid", 32'(valid16), 32'h0);
    check_output("t6_rst_idx24", 32'(idx24), 32'h0);
    check_output("t6_rst_instr24", 32'(instr24), 32'h0);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    check_output("t6_debounce_restart", 32'(idx16), 32'h0);
    tick();
    check_output("t6_fresh_idx", 32'(idx16), 32'h1);
    check_output("t6_fresh_c0", 32'(instr16), 32'h0055);
    btn16 = 1'b0;
    repeat (7) tick();
    apply_stimulus(1'b0, 8'h66);
    check_output("t6_fresh_valid", 32'(valid16), 32'h1);
    check_output("t6_fresh_instr", 32'(instr16), 32'h6655);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Parametrised front-end that assembles a wide instruction word from a narrow parallel input, such as DIP switches, one chunk per push-button press. It provides:
- button synchronisation and debounce;
- LSB-first chunk assembly;
- a valid/ready handoff to the CPU fetch/decode stage;
- status outputs for the 7-seg display.
It sits between the board I/O pins and the bit-serial datapath FSM.

Parameters:
IN_W, 8, width of parallel chunk input din
INSTR_W, 16, instruction width; must be an integer multiple of IN_W (NCHUNK = INSTR_W/IN_W, NCHUNK >= 1)
SYNC_STAGES, 2, button synchroniser flop count (>= 2)
DEBOUNCE_CYCLES, 4, consecutive cycles the synced button must differ from the debounced level before the level flips (>= 1; 1 = no filtering)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
din  in  IN_W  chunk data, sampled at the capture edge
btn  in  1  raw push button, active-high, asynchronous to clk
abort  in  1  synchronous clear of any partial or held instruction
instr_out  out  INSTR_W  assembled instruction; stable while instr_valid=1
instr_valid  out  1  instruction complete, awaiting consumer
instr_ready  in  1  consumer accepts when instr_valid & instr_ready
chunk_idx  out  CW  index of next chunk expected; CW = max(1, clog2(NCHUNK))
hold  out  1  1 in S_HOLD (display shows "ready"), 0 in S_FILL
overrun  out  1  sticky: a press occurred while in S_HOLD

Behaviour:
- Reset values (async, rst_n=0):
  - synchroniser flops, debounced level and debounce counter all 0;
  - state S_FILL, chunk_idx 0, instr_out 0;
  - instr_valid 0, hold 0, overrun 0.
- Synchroniser: btn passes through SYNC_STAGES flops giving btn_s.
- Debounce:
  - Counter increments each cycle btn_s != deb_level.
  - Counter resets to 0 on any cycle btn_s == deb_level.
  - When btn_s != deb_level and counter == DEBOUNCE_CYCLES-1, deb_level toggles at that edge and the counter clears.
- Press strobe: asserted at the edge where deb_level goes 0->1.
  - With defaults, din is captured on the 6th rising clk edge after btn rises (SYNC_STAGES + DEBOUNCE_CYCLES), provided btn stays high.
  - Release (1->0) is filtered identically and produces no strobe.
- FSM S_FILL:
  - On strobe, din is written to instr_out[chunk_idx*IN_W +: IN_W] and chunk_idx increments.
  - When the captured chunk is index NCHUNK-1: chunk_idx returns to 0, state goes to S_HOLD, and instr_valid=1 from the next cycle.
  - Chunks not yet written retain their previous values.
- FSM S_HOLD:
  - instr_valid=1, hold=1, instr_out frozen.
  - On instr_valid & instr_ready: transfer completes, and S_FILL, instr_valid=0 apply from the next cycle.
  - instr_valid is never dropped without a transfer, except on abort or reset.
- Strobe in S_HOLD without a transfer: the press is discarded, data is unchanged, and overrun is set to 1.
- Strobe in the same cycle as a transfer: no overrun. din is captured as chunk 0 and chunk_idx becomes 1 (no press lost).
- abort=1 (synchronous, highest priority):
  - Effects next edge: state S_FILL, chunk_idx 0, instr_valid 0, overrun 0.
  - instr_out is not cleared.
  - A strobe in the same cycle is dropped.
- NCHUNK=1: every accepted strobe goes directly to S_HOLD.
- Reset mid-fill or mid-hold discards all progress, including the debounce state.
- Throughput: at most one transfer per completed instruction; the consumer may hold instr_ready high permanently, in which case instr_valid is a 1-cycle pulse.

Test Plan:
1. Defaults; din=0xA5 then press; din=0x3C then press; instr_ready=1 -> instr_out=0x3CA5, instr_valid high exactly 1 cycle, chunk_idx sequence 0,1,0.
2. Bounce: btn high 3 cycles, low 1, high 3, low -> no capture, chunk_idx stays 0. A clean 6-cycle hold -> capture on the 6th edge.
3. Backpressure: instr_ready=0 after 0x3CA5 completes; third press with din=0xFF -> overrun=1, instr_out stays 0x3CA5, valid held. Then instr_ready=1 -> transfer, overrun still 1 until abort.
4. Abort after one chunk (0x11) -> chunk_idx=0. Next presses 0x22, 0x33 -> instr_out=0x3322.
5. INSTR_W=24, IN_W=8: chunks 0x01, 0x02, 0x03 -> 0x030201. Press coinciding with the transfer edge -> captured as chunk 0, chunk_idx=1, overrun=0.
6. rst_n pulsed low mid-fill (chunk_idx=1) -> all outputs reset asynchronously; next two presses form a fresh instruction.
